// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder: DIGIT bits per clock, LSB first, start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;

  logic [DIGIT:0]   dsum_d;
  logic [WIDTH-1:0] sum_d;

  always_comb begin
    dsum_d = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);
    // New digit enters at the MSB end so the LSB digit lands at bit 0 after NDIG steps.
    sum_d  = (sum_q >> DIGIT) | (WIDTH'(dsum_d[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  logic msb_cin_d;

  // Carry into the MSB recovered from the top bit of the final digit.
  assign msb_cin_d = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum_d[DIGIT-1];
  assign ovf       = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= dsum_d[DIGIT];
          sum_q   <= sum_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cout_q  <= dsum_d[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= msb_cin_d ^ dsum_d[DIGIT];
`endif
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: DIGIT=1 and DIGIT=4 instances (WIDTH=8) checked against
// plain a+b+cin arithmetic; ovf checks active when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       st1 = 1'b0, ci1 = 1'b0, st4 = 1'b0, ci4 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0;
  logic       bz1, dn1, co1, bz4, dn4, co4;
  logic [7:0] s1, s4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ov1, ov4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(ci1),
    .busy(bz1), .done(dn1), .sum(s1), .cout(co1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ov1)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .cin(ci4),
    .busy(bz4), .done(dn4), .sum(s4), .cout(co4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ov4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv);
    if (sel == 0) begin st1 = st; a1 = av; b1 = bv; ci1 = cv; end
    else          begin st4 = st; a4 = av; b4 = bv; ci4 = cv; end
  endtask

  task automatic sample(input int sel, output logic bz, output logic dn, output logic [7:0] s,
                        output logic co, output logic ov);
    ov = 1'b0;
    if (sel == 0) begin
      bz = bz1; dn = dn1; s = s1; co = co1;
`ifdef SERIAL_ADDER_OVF_EN
      ov = ov1;
`endif
    end else begin
      bz = bz4; dn = dn4; s = s4; co = co4;
`ifdef SERIAL_ADDER_OVF_EN
      ov = ov4;
`endif
    end
  endtask

  // One add; with hold=1 start stays high and operands keep changing until done is seen.
  task automatic add_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input bit hold);
    int         ndig;
    int         n;
    logic [8:0] exp;
    logic       exp_ovf;
    logic       bz, dn, co, ov;
    logic [7:0] s;
    ndig    = (sel == 0) ? 8 : 2;
    exp     = {1'b0, av} + {1'b0, bv} + {8'd0, cv};
    exp_ovf = (av[7] == bv[7]) && (exp[7] != av[7]);
    @(negedge clk);
    drive(sel, 1'b1, av, bv, cv);
    @(posedge clk);
    @(negedge clk);
    drive(sel, hold, 8'($urandom), 8'($urandom), 1'($urandom));
    n  = 0;
    dn = 1'b0;
    while (!dn && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      sample(sel, bz, dn, s, co, ov);
      if (!dn) begin
        chk("busy_run", {31'd0, bz}, 32'd1);
        if (hold) drive(sel, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      end
    end
    chk("done_seen", {31'd0, dn}, 32'd1);
    chk("latency", n, ndig);
    chk("sum", {24'd0, s}, {24'd0, exp[7:0]});
    chk("cout", {31'd0, co}, {31'd0, exp[8]});
    chk("busy_done", {31'd0, bz}, 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", {31'd0, ov}, {31'd0, exp_ovf});
`endif
    drive(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    $display("add dig=%0d a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d lat=%0d",
             (sel == 0) ? 1 : 4, av, bv, cv, s, co, ov, n);
    @(negedge clk);
    sample(sel, bz, dn, s, co, ov);
    chk("done_pulse_end", {31'd0, dn}, 32'd0);
    chk("idle_busy", {31'd0, bz}, 32'd0);
    chk("sum_held", {24'd0, s}, {24'd0, exp[7:0]});
    chk("cout_held", {31'd0, co}, {31'd0, exp[8]});
  endtask

  initial begin
    logic       bz, dn, co, ov;
    logic [7:0] s;
    int         extra;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int sel = 0; sel < 2; sel++) begin
      sample(sel, bz, dn, s, co, ov);
      chk("rst_busy", {31'd0, bz}, 32'd0);
      chk("rst_done", {31'd0, dn}, 32'd0);
      chk("rst_sum", {24'd0, s}, 32'd0);
      chk("rst_cout", {31'd0, co}, 32'd0);
      chk("rst_ovf", {31'd0, ov}, 32'd0);
    end
    rst_n = 1'b1;

    // Directed vectors
    add_op(0, 8'h5A, 8'h3C, 1'b0, 0);
    add_op(0, 8'hFF, 8'h01, 1'b0, 0);
    add_op(0, 8'hFF, 8'hFF, 1'b1, 0);
    add_op(1, 8'h99, 8'h67, 1'b0, 0);
    add_op(1, 8'hFF, 8'hFF, 1'b1, 0);
    for (int sel = 0; sel < 2; sel++) begin
      add_op(sel, 8'h7F, 8'h01, 1'b0, 0);
      add_op(sel, 8'h80, 8'hFF, 1'b0, 0);
      add_op(sel, 8'h10, 8'h20, 1'b0, 0);
    end

    // Start held through busy with operands changing; no extra done afterwards
    for (int sel = 0; sel < 2; sel++) begin
      add_op(sel, 8'hA5, 8'h4B, 1'b1, 1);
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        sample(sel, bz, dn, s, co, ov);
        if (dn) extra++;
      end
      chk("no_extra_done", extra, 0);
      chk("idle_after_hold", {31'd0, bz}, 32'd0);
    end

    // Reset in the middle of a run
    @(negedge clk);
    drive(0, 1'b1, 8'h12, 8'h34, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    sample(0, bz, dn, s, co, ov);
    chk("abort_busy", {31'd0, bz}, 32'd0);
    chk("abort_done", {31'd0, dn}, 32'd0);
    chk("abort_sum", {24'd0, s}, 32'd0);
    chk("abort_cout", {31'd0, co}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn1) extra++;
    end
    chk("abort_no_done", extra, 0);
    add_op(0, 8'hC3, 8'h3D, 1'b1, 0);

    // Random traffic on both instances
    for (int i = 0; i < 150; i++)
      add_op(0, 8'($urandom), 8'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 1000; i++)
      add_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
